// File: rtl/exhaustive_equiv_checker.sv
// Exhaustive equivalence sequencer: sweeps every input vector, compares all
// implementation outputs against implementation 0 and records the first failure.
module exhaustive_equiv_checker #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_IMPL = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_IMPL-1:0] impl_y,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_err_valid,
  output logic [N_IN-1:0]   first_err_vec,
  output logic [N_IMPL-1:0] first_err_mask
);

  localparam int unsigned     CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   RELOAD  = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_IN:0]       err_q, err_d;
  logic                fv_q, fv_d;
  logic [N_IN-1:0]     fvec_q, fvec_d;
  logic [N_IMPL-1:0]   fmask_q, fmask_d;
  logic [N_IMPL-1:0]   mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      fmask_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
    end
  end

  // Bit 0 of the mask is always zero since implementation 0 is the reference.
  always_comb mask = impl_y ^ {N_IMPL{impl_y[0]}};

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    fmask_d = fmask_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          vec_d   = '0;
          cnt_d   = RELOAD;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
          fmask_d = '0;
        end
      end
      S_APPLY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        else             state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mask != '0) begin
          err_d = err_q + ERR_ONE;
          if (!fv_q) begin
            fv_d    = 1'b1;
            fvec_d  = vec_q;
            fmask_d = mask;
          end
        end
        if (vec_q == '1) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = RELOAD;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vec_out         = vec_q;
  assign busy            = (state_q == S_APPLY) || (state_q == S_CHECK);
  assign done            = (state_q == S_DONE);
  assign pass            = (state_q == S_DONE) && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_valid = fv_q;
  assign first_err_vec   = fvec_q;
  assign first_err_mask  = fmask_q;

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Bench for exhaustive_equiv_checker: a timing/arithmetic model of each run is
// compared against two DUT instances every cycle, plus literal result checks.
module tb_exhaustive_equiv_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startA = 1'b0, startB = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic [2:0] implA;
  logic [3:0] vecA, fvecA;
  logic       busyA, doneA, passA, fvA;
  logic [4:0] errA;
  logic [2:0] fmaskA;

  exhaustive_equiv_checker #(.N_IN(4), .N_IMPL(3), .SETTLE(1)) dutA (
    .clk(clk), .rst(rst), .start(startA), .impl_y(implA), .vec_out(vecA),
    .busy(busyA), .done(doneA), .pass(passA), .err_count(errA),
    .first_err_valid(fvA), .first_err_vec(fvecA), .first_err_mask(fmaskA)
  );

  // Instance B: N_IN=3, SETTLE=3, glitchy implementations
  logic [2:0] implB = '0;
  logic [2:0] vecB, fvecB;
  logic       busyB, doneB, passB, fvB;
  logic [3:0] errB;
  logic [2:0] fmaskB;

  exhaustive_equiv_checker #(.N_IN(3), .N_IMPL(3), .SETTLE(3)) dutB (
    .clk(clk), .rst(rst), .start(startB), .impl_y(implB), .vec_out(vecB),
    .busy(busyB), .done(doneB), .pass(passB), .err_count(errB),
    .first_err_valid(fvB), .first_err_vec(fvecB), .first_err_mask(fmaskB)
  );

  int checks = 0;
  int errors = 0;
  int modeA  = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Implementations under comparison for instance A, driven from its vector.
  always_comb begin
    logic f;
    f = vecA[0] ^ vecA[3];
    case (modeA)
      1:       implA = {f ^ (vecA == 4'b0101), f, f};
      2:       implA = 3'b010;
      default: implA = {3{f}};
    endcase
  end

  // Expected mismatch mask for vector v under a given scenario.
  function automatic int unsigned exp_mask(input int md, input int unsigned v);
    case (md)
      1:       return (v == 5) ? 4 : 0;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] vec;
    logic        busy, done, pass, fv;
    logic [31:0] err, fvec, fmask;
  } exp_t;

  // t = rising edges since the edge that accepted start; each vector costs
  // SETTLE+1 cycles, and vectors below t/(SETTLE+1) have been judged.
  function automatic exp_t model(input bit started, input int t, input int n,
                                 input int s, input int md);
    exp_t e;
    int p, nv, comp;
    e = '0;
    if (!started) return e;
    p  = s + 1;
    nv = 1 << n;
    if (t < nv * p) begin
      e.vec  = t / p;
      e.busy = 1'b1;
      comp   = t / p;
    end else begin
      e.vec  = nv - 1;
      e.done = 1'b1;
      comp   = nv;
    end
    for (int v = 0; v < comp; v++) begin
      if (exp_mask(md, v) != 0) begin
        e.err++;
        if (!e.fv) begin
          e.fv    = 1'b1;
          e.fvec  = v;
          e.fmask = exp_mask(md, v);
        end
      end
    end
    e.pass = e.done && (e.err == 0);
    return e;
  endfunction

  bit stA = 0, stB = 0;
  int tA = 0, tB = 0, runmodeA = 0;
  localparam int LA = 16 * 2;
  localparam int LB = 8 * 4;

  always @(posedge clk) begin
    if (rst) begin
      stA = 0; tA = 0; stB = 0; tB = 0;
    end else begin
      if (startA && (!stA || tA >= LA)) begin stA = 1; tA = 0; runmodeA = modeA; end
      else if (stA && tA < LA) tA++;
      if (startB && (!stB || tB >= LB)) begin stB = 1; tB = 0; end
      else if (stB && tB < LB) tB++;
    end
  end

  // B's implementations only agree during the CHECK cycle; elsewhere they glitch.
  always @(negedge clk) begin
    logic f;
    f = implB_vec_f(vecB);
    if (stB && tB < LB && (tB % 4) == 3) implB <= {3{f}};
    else                                   implB <= 3'($urandom_range(0, 7));
  end

  function automatic logic implB_vec_f(input logic [2:0] v);
    return v[0] ^ v[2];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_t e;
      e = model(stA, tA, 4, 1, runmodeA);
      chk("A.vec_out", 32'(vecA), e.vec);
      chk("A.busy", 32'(busyA), 32'(e.busy));
      chk("A.done", 32'(doneA), 32'(e.done));
      chk("A.pass", 32'(passA), 32'(e.pass));
      chk("A.err_count", 32'(errA), e.err);
      chk("A.first_err_valid", 32'(fvA), 32'(e.fv));
      chk("A.first_err_vec", 32'(fvecA), e.fvec);
      chk("A.first_err_mask", 32'(fmaskA), e.fmask);
      e = model(stB, tB, 3, 3, 0);
      chk("B.vec_out", 32'(vecB), e.vec);
      chk("B.busy", 32'(busyB), 32'(e.busy));
      chk("B.done", 32'(doneB), 32'(e.done));
      chk("B.err_count", 32'(errB), e.err);
      chk("B.first_err_valid", 32'(fvB), 32'(e.fv));
    end
  end

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) startB = 1'b1; else startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic wait_done(input bit b, input string nm, input int lat);
    int n = 0;
    while (!(b ? doneB : doneA) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, n, lat);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1;
    chk("reset.vec", 32'(vecA), 0);
    chk("reset.busy", 32'(busyA), 0);
    chk("reset.done", 32'(doneA), 0);

    // 1: all equivalent
    modeA = 0;
    pulse_start(0);
    wait_done(0, "s1.latency", 32);
    chk("s1.pass", 32'(passA), 1);
    chk("s1.err", 32'(errA), 0);
    chk("s1.fv", 32'(fvA), 0);
    chk("s1.vec", 32'(vecA), 4'b1111);

    // 2: impl 2 inverted at vector 5
    modeA = 1;
    pulse_start(0);
    wait_done(0, "s2.latency", 32);
    chk("s2.err", 32'(errA), 1);
    chk("s2.fvec", 32'(fvecA), 4'b0101);
    chk("s2.fmask", 32'(fmaskA), 3'b100);
    chk("s2.pass", 32'(passA), 0);

    // 3: impl 1 stuck at one
    modeA = 2;
    pulse_start(0);
    wait_done(0, "s3.latency", 32);
    chk("s3.err", 32'(errA), 16);
    chk("s3.fvec", 32'(fvecA), 0);
    chk("s3.fmask", 32'(fmaskA), 3'b010);

    // 5: restart from DONE with equivalent impls
    modeA = 0;
    pulse_start(0);
    chk("s5.err_cleared", 32'(errA), 0);
    chk("s5.fv_cleared", 32'(fvA), 0);
    wait_done(0, "s5.latency", 32);
    chk("s5.pass", 32'(passA), 1);

    // 4: ignored start while busy, then reset mid-run
    modeA = 2;
    pulse_start(0);
    begin
      int n = 0;
      while (vecA != 4'b0111 && n < 100) begin @(posedge clk); #1; n++; end
      chk("s4.reach7", 32'(vecA), 4'b0111);
    end
    pulse_start(0);
    chk("s4.no_restart_vec", 32'(vecA != 0), 1);
    chk("s4.still_busy", 32'(busyA), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("s4.rst_vec", 32'(vecA), 0);
    chk("s4.rst_busy", 32'(busyA), 0);
    chk("s4.rst_err", 32'(errA), 0);
    chk("s4.rst_done", 32'(doneA), 0);

    // 6: N_IN=3, SETTLE=3 with glitching impls outside CHECK
    pulse_start(1);
    wait_done(1, "s6.latency", 32);
    chk("s6.pass", 32'(passB), 1);
    chk("s6.err", 32'(errB), 0);
    chk("s6.vec", 32'(vecB), 3'b111);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
